alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU in the MIPS execute stage. It accepts one operation per valid/ready transfer and registers the result with zero, overflow and carry flags. It adds NOR, shifts, signed/unsigned compare and an optional multi-cycle multiply. Results are held stable until the consumer accepts them, so the execute stage can stall on multiply without losing data.

## Interface
- `WIDTH`, 32: operand and result width (≥ 8, power of two).
- `SHW`, $clog2(WIDTH): shift-amount width (derived).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation this cycle.
- `A`, `B`  in  WIDTH  operands.
- `ALUcontrol`  in  4  opcode.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  consumer accepts the result.
- `ALUresult`  out  WIDTH  result.
- `zero`  out  1  `ALUresult == 0`, valid for every opcode.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 otherwise.
- `carry`  out  1  carry-out (ADD) or no-borrow (SUB); 0 otherwise.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLTU, 1100 NOR.
  - 1000 SLL, 1001 SRL, 1011 SRA; the shift amount is `B[SHW-1:0]` and the operand is `A`.
  - 1010 MUL: low WIDTH bits of `A*B`.
- ADD/SUB are computed at WIDTH+1 bits. `carry` is bit WIDTH. `overflow` is set when the operand signs agree (ADD) or differ (SUB) and the result sign differs from `A`.
- Unknown opcode: `ALUresult` = 0, `zero` = 1, `overflow` = `carry` = 0. Completes single-cycle.
- FSM states IDLE, MUL, DONE:
  - IDLE: `in_ready` = 1. On transfer of a non-MUL op, register the result and go to DONE. On transfer of MUL, go to MUL.
  - MUL: `in_ready` = 0. Shift-add one bit per cycle for WIDTH cycles, then register the result and go to DONE.
  - DONE: `out_valid` = 1. `in_ready` = `out_ready`. On `out_ready` with no new transfer, go to IDLE. On `out_ready` with a transfer, handle it as in IDLE (back-to-back).
- Operands and opcode are captured at transfer. Input changes afterwards have no effect.
- While `out_valid` is high and `out_ready` is low, all outputs hold stable.

## Timing
- Reset (`rst` = 0 at an edge): state IDLE, `out_valid` = 0, `ALUresult` = 0, `zero` = 0, `overflow` = 0, `carry` = 0, multiplier cleared. `in_ready` is 0 during the reset cycle.
- Reset mid-multiply aborts the operation. No result is emitted.
- Single-cycle op transferred at edge N: `out_valid` is high after edge N.
- MUL transferred at edge N: `out_valid` is high after edge N+WIDTH+1.
- Sustained throughput with `out_ready` held at 1: one single-cycle op per clock.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state and multiplier are instantiated; opcode 1010 behaves as above.
- `ALU_SEQ_MUL_EN` undefined: no MUL state and no multiplier. Opcode 1010 is treated as unknown (single-cycle, result 0).

## Structure
- Shared package `alu_pkg`: opcode localparams (`ALU_AND` … `ALU_MUL`) and the state enum `alu_state_t`.
- Sub-module `alu_mul_seq`: shift-add multiplier with start/done and WIDTH-bit low-product output. It is instantiated only under `ALU_SEQ_MUL_EN`.

## Test plan
- WIDTH = 32, ADD with `A` = 0x7FFFFFFF, `B` = 1 → `ALUresult` = 0x80000000, `overflow` = 1, `carry` = 0, `zero` = 0, 1-cycle latency.
- SUB with `A` = `B` = 0x1234 → result 0, `zero` = 1, `carry` = 1. SLT with `A` = 0xFFFFFFFF, `B` = 1 → 1. SLTU with the same operands → 0.
- SRA with `A` = 0x80000000, `B` = 4 → 0xF8000000. SLL with `B` = 33 uses amount 1 → `A << 1`.
- MUL with `A` = 0xFFFF, `B` = 0x10001 → 0xFFFFFFFF after 33 cycles, with `in_ready` = 0 throughout. Without the macro, the same stimulus → 0 after 1 cycle.
- Hold `out_ready` = 0 for 5 cycles after a result → outputs stable, `in_ready` = 0. Then assert `out_ready` with a new `in_valid` → the new result appears the next cycle.
- Assert `rst` = 0 at cycle 10 of a MUL → the next cycle shows IDLE, `out_valid` = 0, all outputs 0, and no stale result later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked execute-stage ALU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // Opcodes carried on ALUcontrol
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Control FSM states. ST_MUL is only reachable when the multiplier is built.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier producing the low WIDTH bits of a*b.
// Latency: start at edge N -> done high after edge N+WIDTH, cleared on the following edge.
// Backpressure: none; the owner must sample product on the cycle done is high.
// Ports: clk, rst (sync, active-low), start (load a/b), a, b, done, product.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                // One multiplier bit per cycle; bits shifted past WIDTH cannot reach the low product.
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                // Owner takes the product on this edge.
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result and zero/overflow/carry flags.
// Latency: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL (only with ALU_SEQ_MUL_EN defined).
// Backpressure: result held stable while out_valid && !out_ready; in_ready = out_ready in DONE.
// Ports: clk, rst (sync, active-low), in_valid/in_ready + A, B, ALUcontrol in;
//        out_valid/out_ready + ALUresult, zero, overflow, carry out.
// Build option: define ALU_SEQ_MUL_EN to include the sequential multiplier (opcode 1010);
//        otherwise 1010 behaves as an unknown opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    alu_state_t       state;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             ovf_q;
    logic             cry_q;

    logic             xfer;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] c_res;
    logic             c_ovf;
    logic             c_cry;

    assign shamt = B[SHW-1:0];

    // Combinational single-cycle datapath
    always_comb begin
        sum_ext = {1'b0, A} + {1'b0, B};
        // A + ~B + 1: bit WIDTH is the no-borrow flag
        dif_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        c_res   = '0;
        c_ovf   = 1'b0;
        c_cry   = 1'b0;
        case (ALUcontrol)
            ALU_AND:  c_res = A & B;
            ALU_OR:   c_res = A | B;
            ALU_NOR:  c_res = ~(A | B);
            ALU_ADD: begin
                c_res = sum_ext[WIDTH-1:0];
                c_cry = sum_ext[WIDTH];
                c_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                c_res = dif_ext[WIDTH-1:0];
                c_cry = dif_ext[WIDTH];
                c_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: c_res = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  c_res = A << shamt;
            ALU_SRL:  c_res = A >> shamt;
            ALU_SRA:  c_res = $unsigned($signed(A) >>> shamt);
            default:  c_res = '0;
        endcase
    end

    // in_ready forced low while reset is asserted
    assign in_ready = rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign xfer     = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign mul_start = xfer && (ALUcontrol == ALU_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            cry_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (xfer) begin
`ifdef ALU_SEQ_MUL_EN
                        if (mul_start) begin
                            state <= ST_MUL;
                        end else begin
                            state  <= ST_DONE;
                            res_q  <= c_res;
                            zero_q <= (c_res == '0);
                            ovf_q  <= c_ovf;
                            cry_q  <= c_cry;
                        end
`else
                        state  <= ST_DONE;
                        res_q  <= c_res;
                        zero_q <= (c_res == '0);
                        ovf_q  <= c_ovf;
                        cry_q  <= c_cry;
`endif
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state  <= ST_DONE;
                        res_q  <= mul_prod;
                        zero_q <= (mul_prod == '0);
                        ovf_q  <= 1'b0;
                        cry_q  <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_DONE);
    assign ALUresult = res_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry     = cry_q;

endmodule
